// File: rtl/bitstream_loader.sv
// bitstream_loader: serializes valid/ready configuration words MSB-first
// into a left-shifting fabric configuration scan chain.
//
// Ports:
//   clock, reset_n            clock and synchronous active-low reset
//   start                     begins a load from IDLE, DONE or ERROR
//   in_data/in_valid/in_ready word handshake
//   in_parity                 even parity over {in_data, in_parity}
//                             (only with LOADER_PARITY_EN)
//   cfg_bit/cfg_shift/cfg_clear  chain head drive
//   busy/done/error           load status
//
// Optional feature macro: LOADER_PARITY_EN (parity check and ERROR state).
module bitstream_loader #(
    parameter int WORD_WIDTH   = 8,
    parameter int CHAIN_LENGTH = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] in_data,
`ifdef LOADER_PARITY_EN
    input  logic                  in_parity,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  cfg_bit,
    output logic                  cfg_shift,
    output logic                  cfg_clear,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CW = $clog2(CHAIN_LENGTH + 1);
    localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CW-1:0] CL_C  = CW'(CHAIN_LENGTH);
    localparam logic [BW-1:0] BLAST = BW'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE,
        ERROR
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bidx_q, bidx_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;

    logic bit_q, bit_d;
    logic shift_q, shift_d;
    logic clear_q, clear_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic error_q, error_d;

    logic [CW-1:0] cnt_inc;
    logic          last_bit;
    logic          word_end;
    logic          accept;
    logic          parity_ok;

    assign cnt_inc  = cnt_q + 1'b1;
    // The chain is full after this shift; any remaining word bits are dropped.
    assign last_bit = (cnt_inc == CL_C);
    assign word_end = (bidx_q == BLAST);
    assign accept   = in_valid & in_ready;

`ifdef LOADER_PARITY_EN
    assign parity_ok = ~^{in_data, in_parity};
`else
    assign parity_ok = 1'b1;
`endif

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            bit_q   <= 1'b0;
            shift_q <= 1'b0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            clear_q <= clear_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                    bidx_d  = '0;
                end
            end
            FETCH: begin
                if (accept) begin
                    word_d  = in_data;
                    bidx_d  = '0;
                    state_d = parity_ok ? SHIFT : ERROR;
                end
            end
            SHIFT: begin
                cnt_d  = cnt_inc;
                word_d = word_q << 1;
                bidx_d = bidx_q + 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end else if (word_end) begin
                    bidx_d = '0;
                    if (accept) begin
                        // Zero-bubble hand-off to the next word.
                        word_d  = in_data;
                        state_d = parity_ok ? SHIFT : ERROR;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: in_ready is a decode; the rest are registered from next state.
    always_comb begin
        in_ready = (state_q == FETCH) ||
                   ((state_q == SHIFT) && word_end && !last_bit);
        shift_d  = (state_d == SHIFT);
        bit_d    = shift_d & word_d[WORD_WIDTH-1];
        clear_d  = start && ((state_q == IDLE) || (state_q == DONE) ||
                             (state_q == ERROR));
        busy_d   = (state_d == FETCH) || (state_d == SHIFT);
        done_d   = (state_d == DONE);
        error_d  = (state_d == ERROR);
    end

    assign cfg_bit   = bit_q;
    assign cfg_shift = shift_q;
    assign cfg_clear = clear_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_bitstream_loader.sv
// tb_bitstream_loader: directed bench
// for bitstream_loader (CL 20 and 16).
module tb_bitstream_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_n;

  logic       a_start, a_valid;
  logic [7:0] a_data;
  logic       a_ready, a_bit, a_shift;
  logic       a_clear, a_busy, a_done, a_err;
  logic       b_start, b_valid;
  logic [7:0] b_data;
  logic       b_ready, b_bit, b_shift;
  logic       b_clear, b_busy, b_done, b_err;
`ifdef LOADER_PARITY_EN
  logic       a_par, b_par;
`endif

  bitstream_loader #(
    .WORD_WIDTH(8),
    .CHAIN_LENGTH(20)
  ) u_a (
    .clock     (clock),
    .reset_n   (rst_n),
    .start     (a_start),
    .in_data   (a_data),
`ifdef LOADER_PARITY_EN
    .in_parity (a_par),
`endif
    .in_valid  (a_valid),
    .in_ready  (a_ready),
    .cfg_bit   (a_bit),
    .cfg_shift (a_shift),
    .cfg_clear (a_clear),
    .busy      (a_busy),
    .done      (a_done),
    .error     (a_err)
  );

  bitstream_loader #(
    .WORD_WIDTH(8),
    .CHAIN_LENGTH(16)
  ) u_b (
    .clock     (clock),
    .reset_n   (rst_n),
    .start     (b_start),
    .in_data   (b_data),
`ifdef LOADER_PARITY_EN
    .in_parity (b_par),
`endif
    .in_valid  (b_valid),
    .in_ready  (b_ready),
    .cfg_bit   (b_bit),
    .cfg_shift (b_shift),
    .cfg_clear (b_clear),
    .busy      (b_busy),
    .done      (b_done),
    .error     (b_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  bit         qa[$];
  bit         qb[$];
  logic [7:0] aw[$];
  logic [7:0] bw[$];

  int a_nshift, a_nclear;
  int a_clear_cyc, a_done_cyc;
  int a_shift_cyc[$];
  int b_nshift, b_done_cyc;
  int b_shift_cyc[$];
  bit b_rdy_at[$];

  int gap_lo = -1;
  int gap_hi = -1;
  int pulse_cyc = -1;
  bit bad_par = 1'b0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: obs %0d exp %0d",
             tag, obs, exp);
    end
  endtask

  task automatic drive();
    a_valid = (aw.size() > 0) &&
              !(cyc >= gap_lo &&
                cyc <= gap_hi);
    a_data  = (aw.size() > 0) ? aw[0]
                              : 8'h00;
    b_valid = (bw.size() > 0);
    b_data  = (bw.size() > 0) ? bw[0]
                              : 8'h00;
`ifdef LOADER_PARITY_EN
    a_par = (^a_data) ^ bad_par;
    b_par = ^b_data;
`endif
  endtask

  task automatic tick();
    bit acc_a, acc_b, e;
    acc_a = a_valid && a_ready;
    acc_b = b_valid && b_ready;
    @(posedge clock);
    #1;
    cyc++;
    if (acc_a && rst_n && aw.size() > 0)
      void'(aw.pop_front());
    if (acc_b && rst_n && bw.size() > 0)
      void'(bw.pop_front());
    if (a_shift) begin
      a_nshift++;
      a_shift_cyc.push_back(cyc);
      if (qa.size() == 0) begin
        chk("a_extra_shift", a_shift, 1'b0);
      end else begin
        e = qa.pop_front();
        chk("a_bit", a_bit, e);
      end
    end
    if (a_clear) begin
      a_nclear++;
      a_clear_cyc = cyc;
    end
    if (a_done && a_done_cyc < 0)
      a_done_cyc = cyc;
    if (b_shift) begin
      b_nshift++;
      b_shift_cyc.push_back(cyc);
      b_rdy_at.push_back(b_ready);
      if (qb.size() == 0) begin
        chk("b_extra_shift", b_shift, 1'b0);
      end else begin
        e = qb.pop_front();
        chk("b_bit", b_bit, e);
      end
    end
    if (b_done && b_done_cyc < 0)
      b_done_cyc = cyc;
    a_start = (cyc == pulse_cyc);
    b_start = 1'b0;
    drive();
  endtask

  task automatic exp_a(
    input logic [23:0] s,
    input int          n
  );
    for (int i = 0; i < n; i++)
      qa.push_back(s[23-i]);
  endtask

  task automatic exp_b(
    input logic [15:0] s
  );
    for (int i = 0; i < 16; i++)
      qb.push_back(s[15-i]);
  endtask

  task automatic start_a();
    cyc = 0;
    a_nshift = 0;
    a_nclear = 0;
    a_clear_cyc = -1;
    a_done_cyc = -1;
    a_shift_cyc.delete();
    a_start = 1'b1;
    drive();
  endtask

  task automatic start_b();
    cyc = 0;
    b_nshift = 0;
    b_done_cyc = -1;
    b_shift_cyc.delete();
    b_rdy_at.delete();
    b_start = 1'b1;
    drive();
  endtask

  task automatic wait_done_a(
    input int budget
  );
    int n;
    n = 0;
    while (a_done_cyc < 0 && n < budget) begin
      tick();
      n++;
    end
    chk("a_done_reached", a_done, 1'b1);
  endtask

  task automatic load_words_a();
    aw.delete();
    aw.push_back(8'hA5);
    aw.push_back(8'h3C);
    aw.push_back(8'hF0);
    exp_a(24'hA53CF0, 20);
  endtask

  task automatic check_plain_load_a(
    input int done_at
  );
    chk("a_done_cycle", a_done_cyc, done_at);
    chk("a_nshift", a_nshift, 20);
    chk("a_nclear", a_nclear, 1);
    chk("a_clear_cycle", a_clear_cyc, 1);
    chk("a_queue_left", qa.size(), 0);
    chk("a_busy_at_done", a_busy, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
    drive();

    tick();
    tick();
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_shift", a_shift, 1'b0);
    chk("rst_clear", a_clear, 1'b0);
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_error", a_err, 1'b0);
    rst_n = 1'b1;
    tick();

    load_words_a();
    start_a();
    chk("t1_idle_ready", a_ready, 1'b0);
    tick();
    chk("t1_c1_clear", a_clear, 1'b1);
    chk("t1_c1_busy", a_busy, 1'b1);
    chk("t1_c1_ready", a_ready, 1'b1);
    wait_done_a(60);
    check_plain_load_a(22);
    chk("t1_first_shift",
        a_shift_cyc[0], 2);
    chk("t1_contig",
        a_shift_cyc[19] - a_shift_cyc[0], 19);
    tick();
    chk("t1_done_held", a_done, 1'b1);
    chk("t1_done_ready", a_ready, 1'b0);
    chk("t1_done_shift", a_shift, 1'b0);

    load_words_a();
    gap_lo = 9;
    gap_hi = 11;
    start_a();
    tick();
    wait_done_a(60);
    check_plain_load_a(25);
    chk("t2_gap",
        a_shift_cyc[8] - a_shift_cyc[7], 4);
    gap_lo = -1;
    gap_hi = -1;

    load_words_a();
    pulse_cyc = 5;
    start_a();
    tick();
    wait_done_a(60);
    check_plain_load_a(22);
    chk("t3_contig",
        a_shift_cyc[19] - a_shift_cyc[0], 19);
    pulse_cyc = -1;

    load_words_a();
    start_a();
    for (int i = 0; i < 20 && a_nshift < 5; i++)
      tick();
    chk("t4_five_bits", a_nshift, 5);
    rst_n = 1'b0;
    aw.delete();
    drive();
    tick();
    chk("t4_rst_shift", a_shift, 1'b0);
    chk("t4_rst_busy", a_busy, 1'b0);
    chk("t4_rst_done", a_done, 1'b0);
    chk("t4_rst_ready", a_ready, 1'b0);
    rst_n = 1'b1;
    qa.delete();
    tick();
    load_words_a();
    start_a();
    tick();
    wait_done_a(60);
    check_plain_load_a(22);

    bw.delete();
    bw.push_back(8'hFF);
    bw.push_back(8'h00);
    bw.push_back(8'hAA);
    exp_b(16'hFF00);
    start_b();
    tick();
    chk("t5_clear", b_clear, 1'b1);
    for (int i = 0; i < 40 && b_done_cyc < 0; i++)
      tick();
    chk("t5_done_reached", b_done, 1'b1);
    chk("t5_done_cycle", b_done_cyc, 18);
    chk("t5_nshift", b_nshift, 16);
    chk("t5_contig",
        b_shift_cyc[15] - b_shift_cyc[0], 15);
    chk("t5_ready_8th", b_rdy_at[7], 1'b1);
    chk("t5_ready_last", b_rdy_at[15], 1'b0);
    chk("t5_queue_left", qb.size(), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_done_ready", b_ready, 1'b0);
    end
    chk("t5_not_accepted", bw.size(), 1);
    chk("t5_err", b_err, 1'b0);

`ifdef LOADER_PARITY_EN
    aw.delete();
    aw.push_back(8'h01);
    bad_par = 1'b1;
    start_a();
    tick();
    tick();
    chk("t6_error", a_err, 1'b1);
    chk("t6_shift", a_shift, 1'b0);
    chk("t6_busy", a_busy, 1'b0);
    chk("t6_done", a_done, 1'b0);
    tick();
    tick();
    chk("t6_error_held", a_err, 1'b1);
    chk("t6_nshift", a_nshift, 0);
    chk("t6_consumed", aw.size(), 0);
    bad_par = 1'b0;
    start_a();
    tick();
    chk("t6_restart_err", a_err, 1'b0);
    chk("t6_restart_busy", a_busy, 1'b1);
    chk("t6_restart_clear", a_clear, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
